// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the 32-bit ALU: evaluates condition codes against the
// architectural NZCV register, buffers ops in a small FIFO and hands them to the register file.
module alu_writeback_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_n,
  input  logic             in_z,
  input  logic             in_c,
  input  logic             in_v,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_set_flags,
  input  logic [3:0]       in_cond,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_result,
  output logic [RD_W-1:0]  wb_rd,
  output logic             wb_we,
  output logic [3:0]       flags_nzcv,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] squashed_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = c;
      4'h3:    pass = !c;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = c & !z;
      4'h9:    pass = !c | z;
      4'hA:    pass = (n == v);
      4'hB:    pass = (n != v);
      4'hC:    pass = !z & (n == v);
      4'hD:    pass = z | (n != v);
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] res_mem_q [DEPTH];
  logic [RD_W-1:0]  rd_mem_q  [DEPTH];
  logic             we_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] squashed_q, squashed_d;

  logic [WIDTH-1:0] head_res_q, head_res_d;
  logic [RD_W-1:0]  head_rd_q, head_rd_d;
  logic             head_we_q, head_we_d;

  logic             push;
  logic             pop;
  logic             pass;
  logic [PTR_W-1:0] rd_ptr_nxt;

  assign in_ready   = (count_q != OCC_W'(DEPTH));
  assign wb_valid   = (count_q != '0);
  assign push       = in_valid & in_ready;
  assign pop        = wb_valid & wb_ready;
  assign pass       = cond_pass(in_cond, flags_q);
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

  // Pointer, occupancy, flag and counter next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flags_d    = flags_q;
    retired_d  = retired_q;
    squashed_d = squashed_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_nxt;
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
    if (push && in_set_flags && pass) flags_d = {in_n, in_z, in_c, in_v};
    if (pop) begin
      if (head_we_q) retired_d  = sat_inc(retired_q);
      else           squashed_d = sat_inc(squashed_q);
    end
  end

  // Head register: loaded from the incoming op when it becomes the only entry,
  // otherwise from the next FIFO slot after a pop; holds when the FIFO drains.
  always_comb begin
    head_res_d = head_res_q;
    head_rd_d  = head_rd_q;
    head_we_d  = head_we_q;
    if (push && ((count_q == '0) || (pop && count_q == OCC_W'(1)))) begin
      head_res_d = in_result;
      head_rd_d  = in_rd;
      head_we_d  = pass;
    end else if (pop && count_q > OCC_W'(1)) begin
      head_res_d = res_mem_q[rd_ptr_nxt];
      head_rd_d  = rd_mem_q[rd_ptr_nxt];
      head_we_d  = we_mem_q[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flags_q    <= 4'b0000;
      retired_q  <= '0;
      squashed_q <= '0;
      head_res_q <= '0;
      head_rd_q  <= '0;
      head_we_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
      retired_q  <= retired_d;
      squashed_q <= squashed_d;
      head_res_q <= head_res_d;
      head_rd_q  <= head_rd_d;
      head_we_q  <= head_we_d;
    end
  end

  // FIFO storage is data only; occupancy alone decides which slots are live
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wr_ptr_q] <= in_result;
      rd_mem_q[wr_ptr_q]  <= in_rd;
      we_mem_q[wr_ptr_q]  <= pass;
    end
  end

  assign wb_result    = head_res_q;
  assign wb_rd        = head_rd_q;
  assign wb_we        = head_we_q;
  assign flags_nzcv   = flags_q;
  assign retired_cnt  = retired_q;
  assign squashed_cnt = squashed_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_alu_writeback_stage;
  localparam int WIDTH = 32;
  localparam int RD_W  = 5;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_n, in_z, in_c, in_v;
  logic [RD_W-1:0]  in_rd;
  logic             in_set_flags;
  logic [3:0]       in_cond;
  logic             wb_valid;
  logic             wb_ready;
  logic [WIDTH-1:0] wb_result;
  logic [RD_W-1:0]  wb_rd;
  logic             wb_we;
  logic [3:0]       flags_nzcv;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] squashed_cnt;

  alu_writeback_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
    .in_rd(in_rd), .in_set_flags(in_set_flags), .in_cond(in_cond),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .flags_nzcv(flags_nzcv),
    .retired_cnt(retired_cnt), .squashed_cnt(squashed_cnt)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [RD_W-1:0]  rd;
    logic             we;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] mflags;
  int         mret;
  int         msq;

  function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    case (cond)
      4'h0: return z;           4'h1: return !z;
      4'h2: return c;           4'h3: return !c;
      4'h4: return n;           4'h5: return !n;
      4'h6: return v;           4'h7: return !v;
      4'h8: return c && !z;     4'h9: return !c || z;
      4'hA: return n == v;      4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    mflags = 4'b0000;
    mret   = 0;
    msq    = 0;
  endtask

  // One clock edge with the currently driven inputs; model follows the edge.
  task automatic tick();
    bit   acc, pop, ok;
    ent_t e;
    acc = in_valid && (mq.size() < DEPTH);
    pop = (mq.size() > 0) && wb_ready;
    ok  = cond_ok(in_cond, mflags);
    @(posedge clk);
    if (pop) begin
      e = mq.pop_front();
      if (e.we) mret = (mret == 65535) ? mret : mret + 1;
      else      msq  = (msq  == 65535) ? msq  : msq + 1;
    end
    if (acc) begin
      e.res = in_result; e.rd = in_rd; e.we = ok;
      mq.push_back(e);
      if (in_set_flags && ok) mflags = {in_n, in_z, in_c, in_v};
    end
    #1;
  endtask

  task automatic drive(input bit vld, input logic [31:0] res, input logic [3:0] nzcv,
                       input bit setf, input logic [3:0] cond, input logic [4:0] rd);
    in_valid = vld; in_result = res; {in_n, in_z, in_c, in_v} = nzcv;
    in_set_flags = setf; in_cond = cond; in_rd = rd;
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; wb_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 32'h0, 4'h0, 0, 4'h0, 5'h0);
    wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    ncmp++; if (wb_valid !== 1'b0) begin nfail++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    ncmp++; if (flags_nzcv !== 4'b0000) begin nfail++; $display("FAIL reset_flags got %b exp 0000", flags_nzcv); end
    ncmp++; if (retired_cnt !== 16'd0 || squashed_cnt !== 16'd0) begin nfail++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", retired_cnt, squashed_cnt); end
    ncmp++; if (wb_result !== 32'h0 || wb_rd !== 5'h0 || wb_we !== 1'b0) begin nfail++; $display("FAIL reset_wb got %h/%h/%b exp 0/0/0", wb_result, wb_rd, wb_we); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    drive(1, 32'h11, 4'b1000, 1, 4'hE, 5'd1); tick();
    drive(1, 32'h22, 4'b0100, 1, 4'hE, 5'd2); tick();
    in_valid = 1'b0;
    ncmp++; if (wb_valid !== 1'b1 || in_ready !== 1'b0) begin nfail++; $display("FAIL midop_full got v=%b r=%b exp v=1 r=0", wb_valid, in_ready); end
    #2 reset = 1'b1;
    #1;
    ncmp++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin nfail++; $display("FAIL midop_async got v=%b r=%b exp v=0 r=1", wb_valid, in_ready); end
    ncmp++; if (flags_nzcv !== 4'b0000) begin nfail++; $display("FAIL midop_flags got %b exp 0000", flags_nzcv); end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    ncmp++; if (wb_valid !== 1'b0 || retired_cnt !== 16'd0 || squashed_cnt !== 16'd0) begin nfail++; $display("FAIL midop_after got v=%b ret=%0d sq=%0d exp 0/0/0", wb_valid, retired_cnt, squashed_cnt); end
  endtask

  task automatic test_add_overflow();
    wb_ready = 1'b0;
    drive(1, 32'h00000001, 4'b0011, 1, 4'hE, 5'd3); tick();
    in_valid = 1'b0;
    ncmp++; if (wb_valid !== 1'b1 || wb_result !== 32'h1 || wb_rd !== 5'd3 || wb_we !== 1'b1) begin nfail++; $display("FAIL add_head got v=%b res=%h rd=%0d we=%b exp 1/00000001/3/1", wb_valid, wb_result, wb_rd, wb_we); end
    ncmp++; if (flags_nzcv !== 4'b0011) begin nfail++; $display("FAIL add_flags got %b exp 0011", flags_nzcv); end
    wb_ready = 1'b1; tick();
    ncmp++; if (retired_cnt !== 16'd1 || wb_valid !== 1'b0) begin nfail++; $display("FAIL add_retire got ret=%0d v=%b exp 1/0", retired_cnt, wb_valid); end
  endtask

  task automatic test_dependent_cond();
    wb_ready = 1'b1;
    drive(1, 32'h0, 4'b0110, 1, 4'hE, 5'd1); tick();
    drive(1, 32'h7, 4'b0000, 0, 4'h0, 5'd2); tick();
    ncmp++; if (wb_we !== 1'b1 || wb_rd !== 5'd2) begin nfail++; $display("FAIL dep_eq got we=%b rd=%0d exp 1/2", wb_we, wb_rd); end
    drive(1, 32'h8, 4'b0000, 0, 4'h1, 5'd4); tick();
    ncmp++; if (wb_we !== 1'b0 || wb_rd !== 5'd4) begin nfail++; $display("FAIL dep_ne got we=%b rd=%0d exp 0/4", wb_we, wb_rd); end
    in_valid = 1'b0; tick();
    ncmp++; if (squashed_cnt !== 16'd1 || retired_cnt !== 16'd3) begin nfail++; $display("FAIL dep_cnts got sq=%0d ret=%0d exp 1/3", squashed_cnt, retired_cnt); end
    ncmp++; if (flags_nzcv !== 4'b0110) begin nfail++; $display("FAIL dep_flags got %b exp 0110", flags_nzcv); end
  endtask

  task automatic test_nv_setflags();
    apply_reset();
    wb_ready = 1'b0;
    drive(1, 32'h80000000, 4'b1000, 1, 4'hF, 5'd9); tick();
    in_valid = 1'b0;
    ncmp++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin nfail++; $display("FAIL nv_we got v=%b we=%b exp 1/0", wb_valid, wb_we); end
    ncmp++; if (flags_nzcv !== 4'b0000) begin nfail++; $display("FAIL nv_flags got %b exp 0000", flags_nzcv); end
    wb_ready = 1'b1; tick();
    ncmp++; if (squashed_cnt !== 16'd1 || retired_cnt !== 16'd0) begin nfail++; $display("FAIL nv_cnts got sq=%0d ret=%0d exp 1/0", squashed_cnt, retired_cnt); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    wb_ready = 1'b0;
    drive(1, 32'hFFFFFFFF, 4'b1000, 0, 4'hE, 5'd1); tick();
    ncmp++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    drive(1, 32'h0E030001, 4'b0000, 0, 4'hE, 5'd2); tick();
    ncmp++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_full got %b exp 0", in_ready); end
    drive(1, 32'h00000005, 4'b0000, 0, 4'hE, 5'd3); tick();
    ncmp++; if (in_ready !== 1'b0 || wb_result !== 32'hFFFFFFFF) begin nfail++; $display("FAIL bp_stall got r=%b res=%h exp 0/ffffffff", in_ready, wb_result); end
    wb_ready = 1'b1; tick();
    ncmp++; if (wb_result !== 32'h0E030001 || wb_rd !== 5'd2) begin nfail++; $display("FAIL bp_drain2 got %h rd=%0d exp 0e030001 rd=2", wb_result, wb_rd); end
    tick();
    ncmp++; if (wb_result !== 32'h00000005 || wb_rd !== 5'd3 || wb_valid !== 1'b1) begin nfail++; $display("FAIL bp_drain3 got %h rd=%0d v=%b exp 00000005 rd=3 v=1", wb_result, wb_rd, wb_valid); end
    in_valid = 1'b0; tick();
    ncmp++; if (wb_valid !== 1'b0 || retired_cnt !== 16'd3) begin nfail++; $display("FAIL bp_done got v=%b ret=%0d exp 0/3", wb_valid, retired_cnt); end
  endtask

  task automatic test_streaming();
    apply_reset();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'(i + 100), 4'b0000, 0, 4'hE, 5'(i));
      tick();
      ncmp++; if (in_ready !== 1'b1 || wb_valid !== 1'b1 || wb_result !== 32'(i + 100)) begin nfail++; $display("FAIL stream_%0d got r=%b v=%b res=%0d exp 1/1/%0d", i, in_ready, wb_valid, wb_result, i + 100); end
    end
    in_valid = 1'b0; tick();
    ncmp++; if (retired_cnt !== 16'd8 || wb_valid !== 1'b0) begin nfail++; $display("FAIL stream_done got ret=%0d v=%b exp 8/0", retired_cnt, wb_valid); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, 4'($urandom), 1'($urandom),
            4'($urandom), 5'($urandom));
      wb_ready = ($urandom_range(0, 9) < 7);
      tick();
      ncmp++; if (in_ready !== (mq.size() < DEPTH) || wb_valid !== (mq.size() > 0)) begin nfail++; $display("FAIL rand_hs cyc %0d got r=%b v=%b exp occ=%0d", cyc, in_ready, wb_valid, mq.size()); end
      ncmp++; if (flags_nzcv !== mflags) begin nfail++; $display("FAIL rand_flags cyc %0d got %b exp %b", cyc, flags_nzcv, mflags); end
      ncmp++; if (retired_cnt !== 16'(mret) || squashed_cnt !== 16'(msq)) begin nfail++; $display("FAIL rand_cnts cyc %0d got %0d/%0d exp %0d/%0d", cyc, retired_cnt, squashed_cnt, mret, msq); end
      if (mq.size() > 0) begin
        ncmp++; if (wb_result !== mq[0].res || wb_rd !== mq[0].rd || wb_we !== mq[0].we) begin nfail++; $display("FAIL rand_head cyc %0d got %h/%0d/%b exp %h/%0d/%b", cyc, wb_result, wb_rd, wb_we, mq[0].res, mq[0].rd, mq[0].we); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_dependent_cond();
    test_nv_setflags();
    test_backpressure();
    test_streaming();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end
endmodule
